// File: rtl/wb_select_stage.sv
// rtl/wb_select_stage.sv - MEM/WB register with 4-source write-back select and load extension
module wb_select_stage #(
  parameter int DATA_W     = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  input  logic                  stall,
  input  logic                  flush,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm_upper,
  input  logic [1:0]            wb_sel,
  input  logic [1:0]            load_size,
  input  logic                  load_unsigned,
  input  logic                  reg_write,
  input  logic [REG_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     wb_data,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic                  wb_we,
  output logic                  wb_valid
);

  localparam logic [DATA_W-1:0] MASK_B = {DATA_W{1'b1}} >> (DATA_W - 8);
  localparam logic [DATA_W-1:0] MASK_H = {DATA_W{1'b1}} >> (DATA_W - 16);
  localparam logic [DATA_W-1:0] MASK_W = {DATA_W{1'b1}} >> (DATA_W - 32);

  logic [DATA_W-1:0]     w_mask;
  logic                  w_sign;
  logic [DATA_W-1:0]     w_load;
  logic [DATA_W-1:0]     w_sel_data;
  logic                  w_we;

  logic [DATA_W-1:0]     r_wb_data;
  logic [REG_ADDR_W-1:0] r_wb_rd;
  logic                  r_wb_we;
  logic                  r_wb_valid;

  // Dword on a 32-bit datapath collapses to the full word: mask is all ones, sign is the top bit.
  always_comb begin
    w_mask = {DATA_W{1'b1}};
    w_sign = mem_rdata[DATA_W-1];
    case (load_size)
      2'd0: begin w_mask = MASK_B; w_sign = mem_rdata[7];  end
      2'd1: begin w_mask = MASK_H; w_sign = mem_rdata[15]; end
      2'd2: begin w_mask = MASK_W; w_sign = mem_rdata[31]; end
      default: begin w_mask = {DATA_W{1'b1}}; w_sign = mem_rdata[DATA_W-1]; end
    endcase
    w_load = (mem_rdata & w_mask) | ((!load_unsigned && w_sign) ? ~w_mask : '0);
  end

  always_comb begin
    w_sel_data = alu_result;
    case (wb_sel)
      2'd0:    w_sel_data = alu_result;
      2'd1:    w_sel_data = w_load;
      2'd2:    w_sel_data = pc_plus4;
      default: w_sel_data = imm_upper;
    endcase
  end

  assign w_we = in_valid & reg_write & (rd_addr != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_data  <= '0;
      r_wb_rd    <= '0;
      r_wb_we    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (flush) begin
      r_wb_we    <= 1'b0;
      r_wb_valid <= 1'b0;
    end else if (!stall) begin
      r_wb_data  <= w_sel_data;
      r_wb_rd    <= rd_addr;
      r_wb_we    <= w_we;
      r_wb_valid <= in_valid;
    end
  end

  assign wb_data  = r_wb_data;
  assign wb_rd    = r_wb_rd;
  assign wb_we    = r_wb_we;
  assign wb_valid = r_wb_valid;

endmodule

// File: tb/tb_wb_select_stage.sv
// tb/tb_wb_select_stage.sv - scoreboard bench for wb_select_stage at DATA_W 64 and 32
module tb_wb_select_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, stall, flush;
  logic [63:0] alu_result, mem_rdata, pc_plus4, imm_upper;
  logic [1:0]  wb_sel, load_size;
  logic        load_unsigned, reg_write;
  logic [4:0]  rd_addr;

  logic [63:0] d64;
  logic [4:0]  rd64;
  logic        we64, v64;
  logic [31:0] d32;
  logic [4:0]  rd32;
  logic        we32, v32;

  int n_vec  = 0;
  int n_miss = 0;

  typedef struct packed {
    logic [63:0] d64;
    logic [31:0] d32;
    logic [4:0]  rd;
    logic        we;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  exp_t m;

  always #5 clk = ~clk;

  wb_select_stage #(.DATA_W(64), .REG_ADDR_W(5)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result), .mem_rdata(mem_rdata), .pc_plus4(pc_plus4),
    .imm_upper(imm_upper), .wb_sel(wb_sel), .load_size(load_size),
    .load_unsigned(load_unsigned), .reg_write(reg_write), .rd_addr(rd_addr),
    .wb_data(d64), .wb_rd(rd64), .wb_we(we64), .wb_valid(v64)
  );

  wb_select_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .stall(stall), .flush(flush),
    .alu_result(alu_result[31:0]), .mem_rdata(mem_rdata[31:0]), .pc_plus4(pc_plus4[31:0]),
    .imm_upper(imm_upper[31:0]), .wb_sel(wb_sel), .load_size(load_size),
    .load_unsigned(load_unsigned), .reg_write(reg_write), .rd_addr(rd_addr),
    .wb_data(d32), .wb_rd(rd32), .wb_we(we32), .wb_valid(v32)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ext64(input logic [63:0] d, input logic [1:0] sz, input logic u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic signed [31:0] w;
    b = d[7:0];
    h = d[15:0];
    w = d[31:0];
    case (sz)
      2'd0:    return u ? 64'(d[7:0])  : 64'(b);
      2'd1:    return u ? 64'(d[15:0]) : 64'(h);
      2'd2:    return u ? 64'(d[31:0]) : 64'(w);
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] ext32(input logic [31:0] d, input logic [1:0] sz, input logic u);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    b = d[7:0];
    h = d[15:0];
    case (sz)
      2'd0:    return u ? 32'(d[7:0])  : 32'(b);
      2'd1:    return u ? 32'(d[15:0]) : 32'(h);
      default: return d;
    endcase
  endfunction

  function automatic logic [63:0] pick64();
    case (wb_sel)
      2'd0:    return alu_result;
      2'd1:    return ext64(mem_rdata, load_size, load_unsigned);
      2'd2:    return pc_plus4;
      default: return imm_upper;
    endcase
  endfunction

  function automatic logic [31:0] pick32();
    case (wb_sel)
      2'd0:    return alu_result[31:0];
      2'd1:    return ext32(mem_rdata[31:0], load_size, load_unsigned);
      2'd2:    return pc_plus4[31:0];
      default: return imm_upper[31:0];
    endcase
  endfunction

  // Inputs are already driven; update the model, push, clock, then pop and compare.
  task automatic step(input string tag, input bit ov = 1'b0,
                      input logic [63:0] ov64 = '0, input logic [31:0] ov32 = '0);
    exp_t e;
    if (flush) begin
      m.valid = 1'b0;
      m.we    = 1'b0;
    end else if (!stall) begin
      m.valid = in_valid;
      m.rd    = rd_addr;
      m.we    = in_valid && reg_write && (rd_addr != 5'd0);
      m.d64   = ov ? ov64 : pick64();
      m.d32   = ov ? ov32 : pick32();
    end
    sb.push_back(m);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".v64"},  64'(v64),  64'(e.valid));
    chk({tag, ".we64"}, 64'(we64), 64'(e.we));
    chk({tag, ".rd64"}, 64'(rd64), 64'(e.rd));
    chk({tag, ".v32"},  64'(v32),  64'(e.valid));
    chk({tag, ".we32"}, 64'(we32), 64'(e.we));
    chk({tag, ".rd32"}, 64'(rd32), 64'(e.rd));
    if (e.valid) begin
      chk({tag, ".d64"}, d64, e.d64);
      chk({tag, ".d32"}, 64'(d32), 64'(e.d32));
    end
  endtask

  task automatic drive(input logic v, input logic [1:0] sel, input logic [1:0] sz,
                       input logic u, input logic rw, input logic [4:0] rd);
    in_valid = v; wb_sel = sel; load_size = sz;
    load_unsigned = u; reg_write = rw; rd_addr = rd;
  endtask

  typedef struct {
    logic [1:0]  sz;
    logic        u;
    logic [63:0] e64;
    logic [31:0] e32;
    string       name;
  } ext_vec_t;

  ext_vec_t ext_tab[7];

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0; stall = 1'b0; flush = 1'b0;
    alu_result = '0; mem_rdata = '0; pc_plus4 = '0; imm_upper = '0;
    wb_sel = '0; load_size = '0; load_unsigned = 1'b0; reg_write = 1'b0; rd_addr = '0;
    m = '0;

    #12;
    chk("rst.d64", d64, 64'd0);
    chk("rst.v64", 64'(v64), 64'd0);
    chk("rst.we64", 64'(we64), 64'd0);
    chk("rst.rd64", 64'(rd64), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // T2: each source in turn
    alu_result = 64'h11; pc_plus4 = 64'h1004; imm_upper = 64'hABCD0000;
    mem_rdata = 64'h0000_0000_0000_0042;
    drive(1, 2'd0, 2'd3, 0, 1, 5'd5); step("sel_alu", 1, 64'h11, 32'h11);
    drive(1, 2'd1, 2'd3, 0, 1, 5'd5); step("sel_mem", 1, 64'h42, 32'h42);
    drive(1, 2'd2, 2'd0, 0, 1, 5'd5); step("sel_pc4", 1, 64'h1004, 32'h1004);
    drive(1, 2'd3, 2'd0, 0, 1, 5'd5); step("sel_imm", 1, 64'hABCD0000, 32'hABCD0000);

    // T3: load extension on both widths
    ext_tab[0] = '{2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FF80, 32'hFFFF_FF80, "lb"};
    ext_tab[1] = '{2'd0, 1'b1, 64'h0000_0000_0000_0080, 32'h0000_0080, "lbu"};
    ext_tab[2] = '{2'd1, 1'b0, 64'hFFFF_FFFF_FFFF_F080, 32'hFFFF_F080, "lh"};
    ext_tab[3] = '{2'd1, 1'b1, 64'h0000_0000_0000_F080, 32'h0000_F080, "lhu"};
    ext_tab[4] = '{2'd2, 1'b0, 64'hFFFF_FFFF_8000_F080, 32'h8000_F080, "lw"};
    ext_tab[5] = '{2'd2, 1'b1, 64'h0000_0000_8000_F080, 32'h8000_F080, "lwu"};
    ext_tab[6] = '{2'd3, 1'b0, 64'h0000_0000_8000_F080, 32'h8000_F080, "ld"};
    mem_rdata = 64'h0000_0000_8000_F080;
    for (int i = 0; i < 7; i++) begin
      drive(1, 2'd1, ext_tab[i].sz, ext_tab[i].u, 1, 5'd9);
      step(ext_tab[i].name, 1, ext_tab[i].e64, ext_tab[i].e32);
    end

    // T4: stall holds A, flush overrides stall, then C captures
    alu_result = 64'hAAAA; drive(1, 2'd0, 2'd0, 0, 1, 5'd7); step("capA");
    alu_result = 64'hBBBB; drive(1, 2'd0, 2'd0, 0, 1, 5'd9);
    stall = 1'b1;
    step("stall1", 1, 64'hAAAA, 32'hAAAA);
    step("stall2", 1, 64'hAAAA, 32'hAAAA);
    flush = 1'b1;
    step("flush_stall");
    flush = 1'b0; stall = 1'b0;
    alu_result = 64'hCCCC; drive(1, 2'd0, 2'd0, 0, 1, 5'd3); step("capC", 1, 64'hCCCC, 32'hCCCC);

    // T5: x0 destination and bubble
    drive(1, 2'd0, 2'd0, 0, 1, 5'd0); step("x0");
    drive(0, 2'd0, 2'd0, 0, 1, 5'd6); step("bubble");

    // random mix including stall/flush
    for (int i = 0; i < 40; i++) begin
      alu_result = {$urandom, $urandom};
      mem_rdata  = {$urandom, $urandom};
      pc_plus4   = {$urandom, $urandom};
      imm_upper  = {$urandom, $urandom};
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom), 2'($urandom),
            1'($urandom), 1'($urandom), 5'($urandom));
      stall = ($urandom_range(0, 4) == 0);
      flush = ($urandom_range(0, 6) == 0);
      step("rand");
    end
    stall = 1'b0; flush = 1'b0;

    // T1: asynchronous reset mid-cycle with a valid instruction captured
    alu_result = 64'h1234; drive(1, 2'd0, 2'd0, 0, 1, 5'd4); step("pre_rst");
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst.d64", d64, 64'd0);
    chk("arst.v64", 64'(v64), 64'd0);
    chk("arst.we64", 64'(we64), 64'd0);
    chk("arst.rd64", 64'(rd64), 64'd0);
    chk("arst.d32", 64'(d32), 64'd0);
    chk("arst.v32", 64'(v32), 64'd0);
    m = '0;
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2'd2, 2'd0, 0, 1, 5'd8); step("post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
